// File: rtl/shift_feed_pkg.sv
// Shared state encodings and sizing helpers for the shift-register feeder.
// Imported by shift_feed_ctrl and shift_feed_cnt.
package shift_feed_pkg;

   localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
   localparam logic [1:0] ST_SHIFT_ENC    = 2'd1;
   localparam logic [1:0] ST_DONE_ENC     = 2'd2;
   localparam logic [1:0] ST_GAP_WAIT_ENC = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE_ENC,
      SHIFT    = ST_SHIFT_ENC,
      DONE     = ST_DONE_ENC,
      GAP_WAIT = ST_GAP_WAIT_ENC
   } state_t;

   // Gap lengths are limited to 0..15 cycles.
   localparam int GAP_CNT_W = 4;

   // Wide enough to hold MSB itself, so the optional parity slot never wraps.
   function automatic int cnt_width(input int msb);
      return (msb < 1) ? 1 : $clog2(msb + 1);
   endfunction

endpackage

// File: rtl/shift_feed_cnt.sv
// Loadable up-counter with a terminal-count flag; load has priority over increment.
// Counting stops at the terminal value, so tc_o stays high until the next load.
module shift_feed_cnt
   import shift_feed_pkg::*;
#(
   parameter int W = GAP_CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic [W-1:0] term_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc_o  = (cnt_q == term_i);
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && !tc_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/shift_feed_ctrl.sv
// Serialises one accepted word onto a shift register's d/en/mode pins; first bit one cycle after accept,
// in_ready only in IDLE. Define SHIFT_FEED_PARITY_EN to append an even-parity bit after the data bits.
module shift_feed_ctrl
   import shift_feed_pkg::*;
#(
   parameter int MSB = 4,
   parameter int GAP = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MSB-1:0] in_data,
   input  logic           in_dir,
   output logic           sh_d,
   output logic           sh_en,
   output logic           sh_mode,
   output logic           busy,
   output logic           done
);

`ifdef SHIFT_FEED_PARITY_EN
   localparam int SHIFT_LEN = MSB + 1;
`else
   localparam int SHIFT_LEN = MSB;
`endif
   localparam int CW = cnt_width(MSB);
   localparam logic [CW-1:0]        BIT_LAST = CW'(SHIFT_LEN - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

   state_t         state_q;
   logic [MSB-1:0] shadow_q;
   logic           dir_q;
   logic           sh_d_q;
   logic           sh_en_q;
   logic           sh_mode_q;
   logic           done_q;

   logic                 accept;
   logic [CW-1:0]        bit_cnt;
   logic                 bit_tc;
   logic                 gap_tc;
   logic [GAP_CNT_W-1:0] gap_cnt_unused;

   logic [MSB-1:0] pick_word;
   logic           pick_dir;
   logic [CW-1:0]  pick_idx;
   logic           bit_d;

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign accept   = in_valid && in_ready;

   assign sh_d    = sh_d_q;
   assign sh_en   = sh_en_q;
   assign sh_mode = sh_mode_q;
   assign done    = done_q;

   shift_feed_cnt #(
      .W (CW)
   ) u_bit_cnt (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (accept),
      .load_val_i ('0),
      .inc_i      (state_q == SHIFT),
      .term_i     (BIT_LAST),
      .cnt_o      (bit_cnt),
      .tc_o       (bit_tc)
   );

   shift_feed_cnt #(
      .W (GAP_CNT_W)
   ) u_gap_cnt (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (state_q == DONE),
      .load_val_i ('0),
      .inc_i      (state_q == GAP_WAIT),
      .term_i     (GAP_LAST),
      .cnt_o      (gap_cnt_unused),
      .tc_o       (gap_tc)
   );

   // Bit for the next SHIFT cycle: from the live input on accept, else from the shadow word.
   always_comb begin
      pick_word = (state_q == IDLE) ? in_data : shadow_q;
      pick_dir  = (state_q == IDLE) ? in_dir  : dir_q;
      pick_idx  = (state_q == IDLE) ? '0 : (bit_cnt + CW'(1));
      bit_d     = 1'b0;
      for (int i = 0; i < MSB; i++) begin
         if (pick_idx == (pick_dir ? CW'(i) : CW'(MSB - 1 - i))) begin
            bit_d = pick_word[i];
         end
      end
`ifdef SHIFT_FEED_PARITY_EN
      if (pick_idx == CW'(MSB)) begin
         bit_d = ^pick_word;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         dir_q     <= 1'b0;
         sh_d_q    <= 1'b0;
         sh_en_q   <= 1'b0;
         sh_mode_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_q   <= SHIFT;
                  shadow_q  <= in_data;
                  dir_q     <= in_dir;
                  sh_d_q    <= bit_d;
                  sh_en_q   <= 1'b1;
                  sh_mode_q <= in_dir;
               end
            end
            SHIFT: begin
               if (bit_tc) begin
                  state_q <= DONE;
                  sh_d_q  <= 1'b0;
                  sh_en_q <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  sh_d_q  <= bit_d;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= (GAP > 0) ? GAP_WAIT : IDLE;
            end
            GAP_WAIT: begin
               if (gap_tc) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/shift_feed_ctrl.md
Name: shift_feed_ctrl

Overview:
Upstream feeder for the bidirectional shift register. It accepts a parallel word over a valid/ready handshake. It then drives that register's serial data, enable and mode pins for exactly MSB clocks, so the register's parallel output equals the accepted word. A one-cycle done pulse marks completion, followed by an optional programmable idle gap.

Parameters:
MSB, 4, word width in bits; matches the downstream register width.
GAP, 0, idle cycles inserted after done before the next word is accepted (0..15).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  MSB  parallel word to serialise
in_dir  input  1  direction for this word, captured with in_data
sh_d  output  1  serial data to the shift register's d pin
sh_en  output  1  shift enable to the shift register's en pin
sh_mode  output  1  direction to the shift register's mode pin
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last bit is presented

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, bit counter=0, shadow word=0, sh_d=0, sh_en=0, sh_mode=0, busy=0, done=0. in_ready decodes to 1 from IDLE, but no transfer is accepted while rst is low.
- States: IDLE -> SHIFT -> DONE -> GAP_WAIT (only if GAP>0) -> IDLE.
- IDLE:
  - in_ready=1.
  - A transfer happens on a rising edge with in_valid && in_ready.
  - On transfer: capture in_data into shadow and in_dir into dir, clear counter, go to SHIFT.
- SHIFT: lasts exactly MSB cycles (cnt 0..MSB-1). sh_d, sh_en and sh_mode are registered.
  - First bit appears the cycle after acceptance (latency 1).
  - sh_en=1 and sh_mode=dir for every SHIFT cycle.
  - dir=0 (register shifts toward MSB, new bit enters bit 0): sh_d=shadow[MSB-1-cnt], MSB first.
  - dir=1 (register shifts toward LSB, new bit enters bit MSB-1): sh_d=shadow[cnt], LSB first.
  - After the last SHIFT cycle, the downstream out equals the captured word.
- DONE: one cycle.
  - done=1, sh_en=0, sh_d=0, sh_mode holds dir.
  - Next state is GAP_WAIT if GAP>0, else IDLE.
- GAP_WAIT: GAP cycles with sh_en=0, then IDLE.
- Throughput: at most one word every MSB+2+GAP cycles.
- Boundary conditions:
  - in_valid and in_data changes outside IDLE are ignored; the word captured at acceptance is used unchanged.
  - Reset asserted mid-SHIFT aborts immediately: no done pulse, and a partial word is left downstream.
  - Counter width is clog2(MSB+1), so no wrap occurs within a word.
  - in_dir toggling mid-word has no effect.

Optional Feature:
Macro SHIFT_FEED_PARITY_EN.
- Defined: SHIFT lasts MSB+1 cycles. The extra final cycle drives sh_d = XOR-reduction of the shadow word (even parity), with sh_en=1 and the same mode. Throughput becomes MSB+3+GAP cycles.
- Undefined: exactly MSB shift cycles, with no parity logic present.

Decomposition:
- Package shift_feed_pkg holds:
  - state encoding localparams (IDLE, SHIFT, DONE, GAP_WAIT);
  - counter-width function/constant;
  - gap-counter width (4).
- Sub-module shift_feed_cnt: loadable up-counter with terminal-count flag, instantiated twice (bit counter and gap counter).

Test Plan:
1. MSB=4, GAP=0, in_data=4'b1011, in_dir=0 -> sh_d = 1,0,1,1 on cycles 1-4 after accept, sh_en=1, sh_mode=0. done=1 on cycle 5; downstream out=1011.
2. Same word with in_dir=1 -> sh_d = 1,1,0,1, sh_mode=1 on cycles 1-4; done on cycle 5; downstream out=1011.
3. in_valid held high with words 4'hA then 4'h5 -> second accepted exactly 6 cycles after the first; in_ready low for cycles 1-5.
4. GAP=2 -> acceptance spacing 8 cycles; busy high for 7 cycles after each accept; sh_en low during the gap.
5. rst pulled low after 2 SHIFT cycles -> all outputs 0 immediately, no done. After release: in_ready=1, and the next word serialises correctly from bit 0 of the sequence.
6. SHIFT_FEED_PARITY_EN defined, in_data=4'b1011, in_dir=0 -> sh_d = 1,0,1,1,1 (parity 1) over 5 enabled cycles; done on cycle 6.
